dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
Shares the single-port data memory between two requesters: m0 (CPU load/store stage) and m1 (DMA/debug port). Arbitrates per cycle with fixed m0 priority plus a starvation guard for m1. Performs byte-enable stores as a same-cycle read-merge-write on the memory's full-word interface, and returns read data through a registered response. Sits between the pipeline MEM stage / DMA engine and the data memory.

Parameters:
STARVE_LIMIT, 4, number of consecutive cycles m1 may be refused before it is force-granted (1..15)
ADDR_W, 32, requester and memory address width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
m0_req  in  1  m0 access request; held stable with its payload until m0_gnt
m0_we  in  1  1=store, 0=load
m0_be  in  4  store byte enables; bit i enables byte lane [8i+7:8i]
m0_addr  in  ADDR_W  byte address, word aligned (bits [1:0] ignored)
m0_wdata  in  32  store data
m0_pc  in  32  PC of the issuing instruction, forwarded for the store trace
m0_gnt  out  1  access performed this cycle
m0_rvalid  out  1  load data valid (cycle after grant)
m0_rdata  out  32  load data
m1_req, m1_we, m1_be, m1_addr, m1_wdata  in  1/1/4/ADDR_W/32  same meaning for m1
m1_gnt  out  1  access performed this cycle
m1_rvalid  out  1  load data valid
m1_rdata  out  32  load data
dm_MemWrite  out  1  memory write strobe
dm_Addr  out  ADDR_W  memory address
dm_WriteData  out  32  merged full-word write data
dm_pc  out  32  PC to memory trace; m0_pc on m0 grant, 32'h0 on m1 grant
dm_RD  in  32  combinational memory read data for dm_Addr

Behaviour:
- Grant logic is combinational per cycle; one access per cycle; grant = cycle the memory is driven.
- Priority: if starve_cnt == STARVE_LIMIT and m1_req, grant m1; else if m0_req grant m0; else if m1_req grant m1; else idle.
- starve_cnt (4-bit register): +1 each cycle m1_req=1 and m1 not granted, saturating at STARVE_LIMIT; cleared on m1 grant or when m1_req=0.
- Idle cycle: dm_MemWrite=0; dm_Addr/dm_WriteData/dm_pc = 0.
- Store with be==4'hF: dm_WriteData = wdata.
- Partial store: dm_WriteData lane i = be[i] ? wdata lane i : dm_RD lane i; dm_MemWrite=1 in grant cycle.
- Store with be==4'h0: granted, dm_MemWrite=0, no rvalid.
- Load: dm_MemWrite=0; dm_RD captured into mN_rdata at grant edge; mN_rvalid=1 the following cycle only (1-cycle latency); rdata holds until next load response for that master.
- Stores produce no rvalid.
- dm_Addr = {addr[ADDR_W-1:2], 2'b00}.
- Back-to-back grants legal; load response of cycle N overlaps grant of cycle N+1.
- Reset (reset==0 at posedge): starve_cnt=0, m0/m1_rvalid=0, m0/m1_rdata=0. Combinational outputs follow: gnt=0, dm_MemWrite=0, dm_Addr/dm_WriteData/dm_pc=0 while reset low, regardless of req. Pending response mid-reset is dropped.

Optional Feature:
DM_ARB_STATS_EN: adds outputs stat_m0_cnt[31:0], stat_m1_cnt[31:0], stat_force_cnt[15:0]; count m0 grants, m1 grants, starvation-forced m1 grants; cleared by reset; counters wrap. Without it: ports and logic absent; behaviour otherwise identical.

Test Plan:
- m0 store addr 0x10, be F, wdata 0xDEADBEEF, pc 0x3000 -> same cycle dm_MemWrite=1, dm_Addr=0x10, dm_WriteData=0xDEADBEEF, dm_pc=0x3000, m0_gnt=1.
- Partial store: memory word 0x11223344, m1 store be 4'b0101, wdata 0xAABBCCDD -> dm_WriteData=0x11BB33DD, dm_pc=0.
- m0 load addr 0x20 with dm_RD=0xCAFEF00D -> m0_gnt at cycle N, m0_rvalid=1 and m0_rdata=0xCAFEF00D at N+1, rvalid=0 at N+2.
- Both request continuously, STARVE_LIMIT=4 -> m0 granted 4 cycles, m1 granted 5th cycle, starve_cnt back to 0, pattern repeats.
- Assert reset=0 with both requesting and a load response pending -> no gnt, dm_MemWrite=0, rvalid=0, rdata=0; first grant to m0 the cycle after reset=1.
- be=0 store from m0 -> m0_gnt=1, dm_MemWrite=0, no rvalid.

Source files
------------

// File: rtl/dm_arbiter.sv
// ============================================================================
// Module   : dm_arbiter
// Purpose  : Two-requester data-memory arbiter: fixed m0 priority with an m1
//            starvation guard, byte-lane read-merge-write stores and
//            registered load responses. Optional counters: DM_ARB_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dm_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_be,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [31:0]       m0_pc,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_be,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
`ifdef DM_ARB_STATS_EN
  output logic [31:0]       stat_m0_cnt,
  output logic [31:0]       stat_m1_cnt,
  output logic [15:0]       stat_force_cnt,
`endif
  output logic              dm_MemWrite,
  output logic [ADDR_W-1:0] dm_Addr,
  output logic [31:0]       dm_WriteData,
  output logic [31:0]       dm_pc,
  input  logic [31:0]       dm_RD
);

  localparam logic [3:0] c_limit = 4'(STARVE_LIMIT);

  logic [3:0]        r_starve_cnt;
  logic              w_force;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_we;
  logic [3:0]        w_be;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic              w_unused_addr_bits;

  // Address bits [1:0] are ignored: the memory is word addressed.
  assign w_unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0]};

  assign w_force = (r_starve_cnt == c_limit) && m1_req;
  assign w_gnt0  = reset && m0_req && !w_force;
  assign w_gnt1  = reset && m1_req && (w_force || !m0_req);
  assign m0_gnt  = w_gnt0;
  assign m1_gnt  = w_gnt1;

  always_comb begin
    w_we    = 1'b0;
    w_be    = 4'h0;
    w_addr  = '0;
    w_wdata = 32'h0;
    if (w_gnt0) begin
      w_we    = m0_we;
      w_be    = m0_be;
      w_addr  = {m0_addr[ADDR_W-1:2], 2'b00};
      w_wdata = m0_wdata;
    end else if (w_gnt1) begin
      w_we    = m1_we;
      w_be    = m1_be;
      w_addr  = {m1_addr[ADDR_W-1:2], 2'b00};
      w_wdata = m1_wdata;
    end
  end

  // Lanes without an enable keep the current memory word (read-merge-write).
  always_comb begin
    dm_WriteData = 32'h0;
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        dm_WriteData[8*i +: 8] = w_be[i] ? w_wdata[8*i +: 8] : dm_RD[8*i +: 8];
      end
    end
  end

  assign dm_MemWrite = w_we && (w_be != 4'h0);
  assign dm_Addr     = w_addr;
  assign dm_pc       = w_gnt0 ? m0_pc : 32'h0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_starve_cnt <= 4'h0;
    end else if (!m1_req || w_gnt1) begin
      r_starve_cnt <= 4'h0;
    end else if (r_starve_cnt < c_limit) begin
      r_starve_cnt <= r_starve_cnt + 4'h1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= 32'h0;
      m1_rdata  <= 32'h0;
    end else begin
      m0_rvalid <= w_gnt0 && !m0_we;
      m1_rvalid <= w_gnt1 && !m1_we;
      if (w_gnt0 && !m0_we) m0_rdata <= dm_RD;
      if (w_gnt1 && !m1_we) m1_rdata <= dm_RD;
    end
  end

`ifdef DM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_m0_cnt    <= 32'h0;
      stat_m1_cnt    <= 32'h0;
      stat_force_cnt <= 16'h0;
    end else begin
      if (w_gnt0) stat_m0_cnt <= stat_m0_cnt + 32'h1;
      if (w_gnt1) stat_m1_cnt <= stat_m1_cnt + 32'h1;
      if (w_gnt1 && w_force) stat_force_cnt <= stat_force_cnt + 16'h1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter (STARVE_LIMIT=4, ADDR_W=32).
`default_nettype none

module tb_dm_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m0_pc, m1_addr, m1_wdata, dm_RD;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, dm_MemWrite;
  logic [31:0] m0_rdata, m1_rdata, dm_Addr, dm_WriteData, dm_pc;
`ifdef DM_ARB_STATS_EN
  logic [31:0] stat_m0_cnt, stat_m1_cnt;
  logic [15:0] stat_force_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  dm_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_pc(m0_pc), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
`ifdef DM_ARB_STATS_EN
    .stat_m0_cnt(stat_m0_cnt), .stat_m1_cnt(stat_m1_cnt),
    .stat_force_cnt(stat_force_cnt),
`endif
    .dm_MemWrite(dm_MemWrite), .dm_Addr(dm_Addr),
    .dm_WriteData(dm_WriteData), .dm_pc(dm_pc), .dm_RD(dm_RD)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; all checks happen mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_req = 0; m0_we = 0; m0_be = 0; m0_addr = 0; m0_wdata = 0; m0_pc = 0;
    m1_req = 0; m1_we = 0; m1_be = 0; m1_addr = 0; m1_wdata = 0;
    dm_RD = 0;
  endtask

  logic exp_g1, prev_g1;
  logic [31:0] prev_rd;

  initial begin
    idle_all();
    reset = 0;
    m0_req = 1; m1_req = 1;
    tick(); tick();
    #1;
    check_val("rst_m0_gnt", 32'(m0_gnt), 32'h0);
    check_val("rst_m1_gnt", 32'(m1_gnt), 32'h0);
    check_val("rst_memwrite", 32'(dm_MemWrite), 32'h0);
    check_val("rst_addr", dm_Addr, 32'h0);
    check_val("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
    check_val("rst_m0_rdata", m0_rdata, 32'h0);

    // Idle after reset release
    reset = 1; idle_all();
    #1;
    check_val("idle_memwrite", 32'(dm_MemWrite), 32'h0);
    check_val("idle_addr", dm_Addr, 32'h0);
    check_val("idle_wdata", dm_WriteData, 32'h0);
    check_val("idle_pc", dm_pc, 32'h0);

    // m0 full-word store
    m0_req = 1; m0_we = 1; m0_be = 4'hF; m0_addr = 32'h10;
    m0_wdata = 32'hDEADBEEF; m0_pc = 32'h3000;
    #1;
    check_val("st_m0_gnt", 32'(m0_gnt), 32'h1);
    check_val("st_m1_gnt", 32'(m1_gnt), 32'h0);
    check_val("st_memwrite", 32'(dm_MemWrite), 32'h1);
    check_val("st_addr", dm_Addr, 32'h10);
    check_val("st_wdata", dm_WriteData, 32'hDEADBEEF);
    check_val("st_pc", dm_pc, 32'h3000);
    tick(); idle_all();
    check_val("st_no_rvalid", 32'(m0_rvalid), 32'h0);

    // m1 partial store on unaligned address
    m1_req = 1; m1_we = 1; m1_be = 4'b0101; m1_addr = 32'h13;
    m1_wdata = 32'hAABBCCDD; dm_RD = 32'h11223344;
    #1;
    check_val("pst_m1_gnt", 32'(m1_gnt), 32'h1);
    check_val("pst_memwrite", 32'(dm_MemWrite), 32'h1);
    check_val("pst_addr", dm_Addr, 32'h10);
    check_val("pst_wdata", dm_WriteData, 32'h11BB33DD);
    check_val("pst_pc", dm_pc, 32'h0);
    tick(); idle_all();
    check_val("pst_no_rvalid", 32'(m1_rvalid), 32'h0);

    // m0 load with one-cycle response
    m0_req = 1; m0_addr = 32'h20; dm_RD = 32'hCAFEF00D; m0_pc = 32'h4000;
    #1;
    check_val("ld_m0_gnt", 32'(m0_gnt), 32'h1);
    check_val("ld_memwrite", 32'(dm_MemWrite), 32'h0);
    check_val("ld_addr", dm_Addr, 32'h20);
    tick(); idle_all(); dm_RD = 32'h12345678;
    check_val("ld_rvalid_n1", 32'(m0_rvalid), 32'h1);
    check_val("ld_rdata_n1", m0_rdata, 32'hCAFEF00D);
    tick();
    check_val("ld_rvalid_n2", 32'(m0_rvalid), 32'h0);
    check_val("ld_rdata_hold", m0_rdata, 32'hCAFEF00D);

    // Store with no byte enables
    m0_req = 1; m0_we = 1; m0_be = 4'h0; m0_addr = 32'h40; m0_wdata = 32'h1;
    #1;
    check_val("be0_gnt", 32'(m0_gnt), 32'h1);
    check_val("be0_memwrite", 32'(dm_MemWrite), 32'h0);
    tick(); idle_all();
    check_val("be0_no_rvalid", 32'(m0_rvalid), 32'h0);

    // Both requesting: m0 stores, m1 loads; m1 forced every 5th cycle
    m0_req = 1; m0_we = 1; m0_be = 4'hF; m0_addr = 32'h80; m0_wdata = 32'h5;
    m1_req = 1; m1_we = 0; m1_addr = 32'h90;
    prev_g1 = 0; prev_rd = 0;
    for (int i = 0; i < 10; i++) begin
      dm_RD = 32'h100 + 32'(i);
      #1;
      exp_g1 = ((i % 5) == 4);
      check_val($sformatf("stv_m0_gnt_%0d", i), 32'(m0_gnt), 32'(!exp_g1));
      check_val($sformatf("stv_m1_gnt_%0d", i), 32'(m1_gnt), 32'(exp_g1));
      check_val($sformatf("stv_m1_rvalid_%0d", i), 32'(m1_rvalid), 32'(prev_g1));
      if (prev_g1) check_val($sformatf("stv_m1_rdata_%0d", i), m1_rdata, prev_rd);
      prev_g1 = exp_g1;
      prev_rd = dm_RD;
      tick();
    end

    // Reset while a load response is pending
    idle_all();
    m0_req = 1; m0_addr = 32'h24; dm_RD = 32'h55AA55AA;
    tick();
    check_val("rp_rvalid_before", 32'(m0_rvalid), 32'h1);
    reset = 0; m1_req = 1; m1_we = 0;
    #1;
    check_val("rp_m0_gnt", 32'(m0_gnt), 32'h0);
    check_val("rp_m1_gnt", 32'(m1_gnt), 32'h0);
    check_val("rp_memwrite", 32'(dm_MemWrite), 32'h0);
    tick();
    check_val("rp_m0_rvalid", 32'(m0_rvalid), 32'h0);
    check_val("rp_m0_rdata", m0_rdata, 32'h0);
    check_val("rp_m1_rdata", m1_rdata, 32'h0);
    reset = 1;
    #1;
    check_val("rp_first_m0_gnt", 32'(m0_gnt), 32'h1);
    check_val("rp_first_m1_gnt", 32'(m1_gnt), 32'h0);
    tick();
    idle_all();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
